// File: rtl/prom_coherente_param.sv
// Coherent averager: sums 2^K frames of M samples point-by-point in a block RAM
// and emits one summed or averaged frame per block, 2-cycle pipeline with forwarding.
//
// state  | meaning
// S_IDLE | waiting for enable with a legal M; config latched on exit
// S_ACUM | accepting samples, accumulating and emitting the last frame
// S_DONE | one-shot block finished; hold until enable drops
module prom_coherente_param #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       ptos_x_ciclo,
  input  logic [3:0]        log2_frames,
  input  logic              modo_media,
  input  logic              modo_continuo,
  input  logic              data_in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_out_valid,
  output logic [ACC_W-1:0]  data_out,
  output logic              busy,
  output logic              done,
  output logic              config_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACUM, S_DONE} state_t;

  state_t st, st_nxt;

  logic [15:0]       m_q;
  logic [3:0]        k_q;
  logic              media_q, cont_q;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       frame;

  logic              m_legal, accept, idx_last, frame_last, blk_last;

  logic              s1_valid, s1_first, s1_lastf;
  logic [ADDR_W-1:0] s1_idx;
  logic [DATA_W-1:0] s1_data;
  logic              s2_valid, s2_first, s2_lastf, s2_fwd;
  logic [ADDR_W-1:0] s2_idx;
  logic [DATA_W-1:0] s2_data;
  logic [ACC_W-1:0]  s2_fwd_val, rd_q;

  logic signed [ACC_W-1:0] base_c, data_ext, sum_c, mean_c;

  logic [ACC_W-1:0] mem [DEPTH];

  assign m_legal    = (ptos_x_ciclo != 16'd0) && (32'(ptos_x_ciclo) <= DEPTH);
  assign accept     = (st == S_ACUM) && enable && data_in_valid;
  assign idx_last   = (32'(idx) + 32'd1 == 32'(m_q));
  assign frame_last = (32'(frame) + 32'd1 == (32'd1 << k_q));
  assign blk_last   = idx_last && frame_last;

  // Frame 0 overwrites the word, so stale RAM content never leaks into a new block.
  assign base_c   = s2_first ? '0 : (s2_fwd ? s2_fwd_val : rd_q);
  assign data_ext = {{(ACC_W-DATA_W){s2_data[DATA_W-1]}}, s2_data};
  assign sum_c    = base_c + data_ext;
  assign mean_c   = sum_c >>> k_q;

  assign busy = (st == S_ACUM);
  assign done = (st == S_DONE) && !s1_valid && !s2_valid;

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE: if (enable && m_legal) st_nxt = S_ACUM;
      S_ACUM: begin
        if (!enable)                           st_nxt = S_IDLE;
        else if (accept && blk_last && !cont_q) st_nxt = S_DONE;
      end
      S_DONE: if (!enable) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st             <= S_IDLE;
      m_q            <= '0;
      k_q            <= '0;
      media_q        <= 1'b0;
      cont_q         <= 1'b0;
      idx            <= '0;
      frame          <= '0;
      config_err     <= 1'b0;
      s1_valid       <= 1'b0;
      s1_first       <= 1'b0;
      s1_lastf       <= 1'b0;
      s1_idx         <= '0;
      s1_data        <= '0;
      s2_valid       <= 1'b0;
      s2_first       <= 1'b0;
      s2_lastf       <= 1'b0;
      s2_fwd         <= 1'b0;
      s2_idx         <= '0;
      s2_data        <= '0;
      s2_fwd_val     <= '0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
    end else begin
      st <= st_nxt;
      if (st == S_IDLE && enable) begin
        if (m_legal) begin
          m_q     <= ptos_x_ciclo;
          k_q     <= log2_frames;
          media_q <= modo_media;
          cont_q  <= modo_continuo;
        end else begin
          config_err <= 1'b1;
        end
      end

      if (st != S_ACUM) begin
        idx   <= '0;
        frame <= '0;
      end else if (accept) begin
        if (idx_last) begin
          idx   <= '0;
          frame <= frame_last ? 16'd0 : frame + 16'd1;
        end else begin
          idx <= idx + ADDR_W'(1);
        end
      end

      s1_valid <= accept;
      s1_idx   <= idx;
      s1_first <= (frame == 16'd0);
      s1_lastf <= frame_last;
      s1_data  <= data_in;

      // Same word written this edge as read: RAM returns old data, so forward the sum.
      s2_valid   <= s1_valid && enable;
      s2_idx     <= s1_idx;
      s2_first   <= s1_first;
      s2_lastf   <= s1_lastf;
      s2_data    <= s1_data;
      s2_fwd     <= s2_valid && (s2_idx == s1_idx);
      s2_fwd_val <= sum_c;

      data_out_valid <= s2_valid && s2_lastf && enable;
      if (s2_valid && s2_lastf) data_out <= media_q ? mean_c : sum_c;
    end
  end

  always_ff @(posedge clk) begin
    if (s2_valid) mem[s2_idx] <= sum_c;
    rd_q <= mem[s1_idx];
  end

endmodule

// File: tb/tb_prom_coherente_param.sv
// Bench for prom_coherente_param: directed and random blocks against a
// per-point sum model, checking every output beat value and its latency.
module tb_prom_coherente_param;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 48;
  localparam int DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [15:0]       ptos_x_ciclo = '0;
  logic [3:0]        log2_frames = '0;
  logic              modo_media = 1'b0;
  logic              modo_continuo = 1'b0;
  logic              data_in_valid = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_out_valid;
  logic [ACC_W-1:0]  data_out;
  logic              busy, done, config_err;

  prom_coherente_param #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .ADDR_W(11)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ptos_x_ciclo(ptos_x_ciclo),
    .log2_frames(log2_frames), .modo_media(modo_media), .modo_continuo(modo_continuo),
    .data_in_valid(data_in_valid), .data_in(data_in), .data_out_valid(data_out_valid),
    .data_out(data_out), .busy(busy), .done(done), .config_err(config_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int     nchk = 0, nerr = 0;
  int     dq[$];
  longint exp_v[$];
  int     exp_c[$];

  task automatic check(input string tag, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset && data_out_valid) begin
      if (exp_v.size() == 0) check("extra_beat", data_out_valid, 0);
      else begin
        check("beat", longint'($signed(data_out)), exp_v.pop_front());
        check("latency", cyc, exp_c.pop_front());
      end
    end
  end

  task automatic start(input int m, input int k, input bit mean, input bit cont);
    ptos_x_ciclo  = 16'(m);
    log2_frames   = 4'(k);
    modo_media    = mean;
    modo_continuo = cont;
    enable        = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic stop();
    enable = 1'b0;
    data_in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fill_rand(input int count);
    for (int i = 0; i < count; i++) dq.push_back(int'($urandom));
  endtask

  // Expected beat i of block b = sum over frames of sample (b, f, i), optionally floor-divided by 2^k.
  task automatic play(input int m, input int k, input bit mean, input int nblk, input int gap);
    int n, per;
    longint s;
    n = 1 << k;
    per = m * n;
    for (int b = 0; b < nblk; b++)
      for (int i = 0; i < m; i++) begin
        s = 0;
        for (int f = 0; f < n; f++) s += longint'(dq[b*per + f*m + i]);
        exp_v.push_back(mean ? (s >>> k) : s);
      end
    for (int x = 0; x < nblk*per; x++) begin
      while (gap != 0 && $urandom_range(99) < gap) begin
        data_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      data_in_valid = 1'b1;
      data_in = dq[x];
      if ((x % per) / m == n - 1) exp_c.push_back(cyc + 3);
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    for (int t = 0; t < 6 && exp_v.size() != 0; t++) @(posedge clk);
    @(negedge clk); #1;
    check("drain", exp_v.size(), 0);
    exp_v.delete();
    exp_c.delete();
    dq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int m, k;
    bit mean, cont;

    #3 reset = 1'b0;
    #7;
    check("rst_valid", data_out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfgerr", config_err, 0);
    #18 reset = 1'b1;
    @(posedge clk); #1;

    // constant 10, mean then sum
    start(4, 2, 1, 0);
    for (int i = 0; i < 16; i++) dq.push_back(10);
    play(4, 2, 1, 1, 0);
    check("done_mean", done, 1);
    stop();
    start(4, 2, 0, 0);
    for (int i = 0; i < 16; i++) dq.push_back(10);
    play(4, 2, 0, 1, 0);
    stop();

    // signed data, sum and floor mean
    start(3, 1, 0, 0);
    dq = '{1, 2, 3, -5, 0, 7};
    play(3, 1, 0, 1, 0);
    stop();
    start(3, 1, 1, 0);
    dq = '{1, 2, 3, -5, 0, 7};
    play(3, 1, 1, 1, 0);
    stop();

    // M=1 forwarding, two back-to-back continuous blocks
    start(1, 3, 0, 1);
    for (int r = 0; r < 2; r++) for (int i = 1; i <= 8; i++) dq.push_back(i);
    play(1, 3, 0, 2, 0);
    check("cont_busy", busy, 1);
    stop();

    // one-shot, inputs after DONE ignored
    start(2, 0, 0, 0);
    fill_rand(2);
    play(2, 0, 0, 1, 0);
    check("oneshot_done", done, 1);
    for (int i = 0; i < 4; i++) begin
      data_in_valid = 1'b1;
      data_in = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("done_hold", done, 1);
    stop();
    check("done_clear", done, 0);

    // abort at frame 1, then a clean block
    start(4, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      data_in_valid = 1'b1;
      data_in = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    enable = 1'b0;
    data_in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("abort_valid", data_out_valid, 0);
    check("abort_busy", busy, 0);
    start(4, 1, 1, 0);
    fill_rand(8);
    play(4, 1, 1, 1, 0);
    stop();

    // random configurations, with and without valid gaps
    for (int r = 0; r < 12; r++) begin
      m    = (r % 4 == 3) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 9));
      k    = $urandom_range(0, 4);
      mean = 1'($urandom_range(0, 1));
      cont = 1'($urandom_range(0, 1));
      start(m, k, mean, cont);
      fill_rand((cont ? 2 : 1) * m * (1 << k));
      play(m, k, mean, cont ? 2 : 1, (r % 2 == 1) ? 30 : 0);
      if (cont) check("rand_busy", busy, 1);
      else      check("rand_done", done, 1);
      stop();
    end
    check("cfgerr_clean", config_err, 0);

    // largest legal M
    start(DEPTH, 0, 0, 0);
    fill_rand(DEPTH);
    play(DEPTH, 0, 0, 1, 0);
    check("depth_done", done, 1);
    stop();

    // M = DEPTH+1 rejected
    start(DEPTH + 1, 0, 0, 0);
    @(posedge clk); #1;
    check("cfg_hi_err", config_err, 1);
    check("cfg_hi_busy", busy, 0);
    stop();

    // asynchronous reset in the middle of a continuous block
    start(2, 0, 0, 1);
    fill_rand(4);
    play(2, 0, 0, 2, 0);
    data_in_valid = 1'b1;
    data_in = DATA_W'(5);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", data_out_valid, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cfgerr", config_err, 0);
    data_in_valid = 1'b0;
    enable = 1'b0;
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // M = 0 rejected
    start(0, 0, 0, 0);
    @(posedge clk); #1;
    check("cfg_zero_err", config_err, 1);
    check("cfg_zero_busy", busy, 0);
    stop();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
